// File: rtl/sobel_scan_controller_pkg.sv
// Shared types for the Sobel scan controller: buffer shift directions, scan FSM
// states and window geometry.
package sobel_pkg;

  localparam int WIN_SIZE   = 3;
  localparam int WIN_PIXELS = 9;

  typedef enum logic [1:0] {
    DIR_LOAD  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } shift_dir_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_FETCH   = 3'd3,
    ST_COMPUTE = 3'd4,
    ST_DONE    = 3'd5
  } scan_state_e;

  // Serpentine step: even bands sweep right, odd bands sweep left, edges go down.
  function automatic shift_dir_e next_dir(input logic odd_band, input logic at_left,
                                          input logic at_right);
    if (odd_band) begin
      return at_left ? DIR_DOWN : DIR_LEFT;
    end else begin
      return at_right ? DIR_DOWN : DIR_RIGHT;
    end
  endfunction

endpackage

// File: rtl/sobel_scan_controller_if.sv
// Frame control, frame-memory read port and window-buffer handshake bundle.
// Optional macro SCAN_PERF_EN adds the perf_stall/perf_windows counters.
interface sobel_scan_controller_if #(parameter int ADDR_W = 20);
  logic              start;
  logic [ADDR_W-1:0] img_base;
  logic              busy;
  logic              frame_done;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              start_shift;
  logic              start_read;
  logic [1:0]        shift_direc;
  logic              win_valid;
  logic [15:0]       win_x;
  logic [15:0]       win_y;
  logic              calc_done;
`ifdef SCAN_PERF_EN
  logic [31:0]       perf_stall;
  logic [31:0]       perf_windows;

  modport master (
    input  start, img_base, rd_ack, calc_done,
    output busy, frame_done, rd_req, rd_addr, start_shift, start_read, shift_direc,
           win_valid, win_x, win_y, perf_stall, perf_windows
  );
  modport slave (
    output start, img_base, rd_ack, calc_done,
    input  busy, frame_done, rd_req, rd_addr, start_shift, start_read, shift_direc,
           win_valid, win_x, win_y, perf_stall, perf_windows
  );
`else
  modport master (
    input  start, img_base, rd_ack, calc_done,
    output busy, frame_done, rd_req, rd_addr, start_shift, start_read, shift_direc,
           win_valid, win_x, win_y
  );
  modport slave (
    output start, img_base, rd_ack, calc_done,
    input  busy, frame_done, rd_req, rd_addr, start_shift, start_read, shift_direc,
           win_valid, win_x, win_y
  );
`endif
endinterface

// File: rtl/sobel_scan_controller_scan_addr_gen.sv
// Window position and read-address generator: tracks (wx,wy), the window row base
// and the read index, stepping addresses with adders only.
module scan_addr_gen
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              init_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              shift_i,
  input  shift_dir_e        dir_i,
  input  logic              ack_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [15:0]       wx_o,
  output logic [15:0]       wy_o,
  output logic              last_read_o,
  output logic              last_win_o,
  output logic              at_left_o,
  output logic              at_right_o,
  output logic              odd_band_o
);

  localparam logic [ADDR_W-1:0] W_STEP    = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] ROW_WRAP  = ADDR_W'(WIDTH - 2);
  localparam logic [ADDR_W-1:0] DOWN_JUMP = ADDR_W'(3 * WIDTH);
  localparam logic [15:0]       WX_MAX    = 16'(WIDTH - 3);
  localparam logic [15:0]       WY_MAX    = 16'(HEIGHT - 3);

  logic [ADDR_W-1:0] row_base_q, rd_addr_q, tl_s;
  logic [15:0]       wx_q, wy_q;
  logic [3:0]        rd_idx_q;
  logic [1:0]        col_q;

  assign tl_s        = row_base_q + ADDR_W'(wx_q);
  assign rd_addr_o   = rd_addr_q;
  assign wx_o        = wx_q;
  assign wy_o        = wy_q;
  assign at_left_o   = (wx_q == 16'd0);
  assign at_right_o  = (wx_q == WX_MAX);
  assign odd_band_o  = wy_q[0];
  assign last_read_o = (dir_i == DIR_LOAD) ? (rd_idx_q == 4'(WIN_PIXELS - 1))
                                           : (rd_idx_q == 4'(WIN_SIZE - 1));
  assign last_win_o  = (wy_q == WY_MAX) && (odd_band_o ? at_left_o : at_right_o);

  // Position/address state; shift presets the first fetch address from the old window.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row_base_q <= '0;
      rd_addr_q  <= '0;
      wx_q       <= 16'd0;
      wy_q       <= 16'd0;
      rd_idx_q   <= 4'd0;
      col_q      <= 2'd0;
    end else if (init_i) begin
      row_base_q <= base_i;
      rd_addr_q  <= base_i;
      wx_q       <= 16'd0;
      wy_q       <= 16'd0;
      rd_idx_q   <= 4'd0;
      col_q      <= 2'd0;
    end else if (shift_i) begin
      rd_idx_q <= 4'd0;
      col_q    <= 2'd0;
      case (dir_i)
        DIR_RIGHT: begin
          wx_q      <= wx_q + 16'd1;
          rd_addr_q <= tl_s + ADDR_W'(3);
        end
        DIR_LEFT: begin
          wx_q      <= wx_q - 16'd1;
          rd_addr_q <= tl_s - ADDR_W'(1);
        end
        DIR_DOWN: begin
          wy_q       <= wy_q + 16'd1;
          row_base_q <= row_base_q + W_STEP;
          rd_addr_q  <= tl_s + DOWN_JUMP;
        end
        default: rd_addr_q <= tl_s;
      endcase
    end else if (ack_i) begin
      rd_idx_q <= rd_idx_q + 4'd1;
      case (dir_i)
        DIR_LOAD: begin
          if (col_q == 2'd2) begin
            col_q     <= 2'd0;
            rd_addr_q <= rd_addr_q + ROW_WRAP;
          end else begin
            col_q     <= col_q + 2'd1;
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        DIR_DOWN: rd_addr_q <= rd_addr_q + ADDR_W'(1);
        default:  rd_addr_q <= rd_addr_q + W_STEP;
      endcase
    end
  end

endmodule

// File: rtl/sobel_scan_controller.sv
// Serpentine 3x3 window scan controller for the Sobel pipeline.
// Optional macro SCAN_PERF_EN adds read-stall and window counters.
module sobel_scan_controller
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              n_rst,
  sobel_scan_controller_if.master bus
);

  scan_state_e state_q;
  shift_dir_e  dir_q;
  logic        busy_q, frame_done_q, rd_req_q, start_shift_q, win_valid_q;
  logic [15:0] win_x_q, win_y_q, wx_s, wy_s;
  logic        init_s, shift_s, ack_s;
  logic        last_read_s, last_win_s, at_left_s, at_right_s, odd_band_s;

  assign init_s  = (state_q == ST_IDLE) && bus.start;
  assign shift_s = (state_q == ST_SHIFT);
  assign ack_s   = rd_req_q && bus.rd_ack;

  scan_addr_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_addr (
    .clk(clk), .n_rst(n_rst),
    .init_i(init_s), .base_i(bus.img_base),
    .shift_i(shift_s), .dir_i(dir_q), .ack_i(ack_s),
    .rd_addr_o(bus.rd_addr), .wx_o(wx_s), .wy_o(wy_s),
    .last_read_o(last_read_s), .last_win_o(last_win_s),
    .at_left_o(at_left_s), .at_right_o(at_right_s), .odd_band_o(odd_band_s)
  );

  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.rd_req      = rd_req_q;
  assign bus.start_read  = ack_s;
  assign bus.start_shift = start_shift_q;
  assign bus.shift_direc = dir_q;
  assign bus.win_valid   = win_valid_q;
  assign bus.win_x       = win_x_q;
  assign bus.win_y       = win_y_q;

  // Scan FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      dir_q         <= DIR_LOAD;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      rd_req_q      <= 1'b0;
      start_shift_q <= 1'b0;
      win_valid_q   <= 1'b0;
      win_x_q       <= 16'd0;
      win_y_q       <= 16'd0;
    end else begin
      frame_done_q  <= 1'b0;
      start_shift_q <= 1'b0;
      win_valid_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            busy_q  <= 1'b1;
            dir_q   <= DIR_LOAD;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD, ST_FETCH: begin
          if (!rd_req_q) begin
            rd_req_q <= 1'b1;
          end else if (bus.rd_ack && last_read_s) begin
            rd_req_q    <= 1'b0;
            win_valid_q <= 1'b1;
            win_x_q     <= wx_s + 16'd1;
            win_y_q     <= wy_s + 16'd1;
            state_q     <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          if (bus.calc_done) begin
            if (last_win_s) begin
              frame_done_q <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              dir_q         <= next_dir(odd_band_s, at_left_s, at_right_s);
              start_shift_q <= 1'b1;
              state_q       <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: state_q <= ST_FETCH;
        ST_DONE: begin
          busy_q  <= 1'b0;
          dir_q   <= DIR_LOAD;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q   <= 1'b0;
          rd_req_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SCAN_PERF_EN
  logic [31:0] perf_stall_q, perf_windows_q;
  assign bus.perf_stall   = perf_stall_q;
  assign bus.perf_windows = perf_windows_q;

  // Saturating per-frame counters, cleared when a frame is accepted.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      perf_stall_q   <= 32'd0;
      perf_windows_q <= 32'd0;
    end else if (init_s) begin
      perf_stall_q   <= 32'd0;
      perf_windows_q <= 32'd0;
    end else begin
      if (rd_req_q && !bus.rd_ack && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (win_valid_q && (perf_windows_q != 32'hFFFF_FFFF)) begin
        perf_windows_q <= perf_windows_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sobel_scan_controller.sv
// Self-checking bench: serpentine-scan reference model, randomized memory/compute
// responder and a per-cycle output compare process.
module tb_sobel_scan_controller;
  localparam int AW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic n_rst;

  sobel_scan_controller_if #(.ADDR_W(AW)) bus_a ();
  sobel_scan_controller_if #(.ADDR_W(AW)) bus_b ();

  sobel_scan_controller #(.WIDTH(4), .HEIGHT(4), .ADDR_W(AW)) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(bus_a.master));
  sobel_scan_controller #(.WIDTH(3), .HEIGHT(5), .ADDR_W(AW)) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(bus_b.master));

  bit sel = 1'b0;
  logic start_v = 1'b0, ack_v = 1'b0, calc_v = 1'b0;
  logic [AW-1:0] base_v = '0;

  assign bus_a.start     = !sel && start_v;
  assign bus_a.img_base  = base_v;
  assign bus_a.rd_ack    = !sel && ack_v;
  assign bus_a.calc_done = !sel && calc_v;
  assign bus_b.start     = sel && start_v;
  assign bus_b.img_base  = base_v;
  assign bus_b.rd_ack    = sel && ack_v;
  assign bus_b.calc_done = sel && calc_v;

  logic m_busy, m_done, m_req, m_ack, m_sread, m_sshift, m_wv;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_dir;
  logic [15:0]   m_wx, m_wy;
  assign m_busy   = sel ? bus_b.busy        : bus_a.busy;
  assign m_done   = sel ? bus_b.frame_done  : bus_a.frame_done;
  assign m_req    = sel ? bus_b.rd_req      : bus_a.rd_req;
  assign m_ack    = sel ? bus_b.rd_ack      : bus_a.rd_ack;
  assign m_sread  = sel ? bus_b.start_read  : bus_a.start_read;
  assign m_sshift = sel ? bus_b.start_shift : bus_a.start_shift;
  assign m_wv     = sel ? bus_b.win_valid   : bus_a.win_valid;
  assign m_addr   = sel ? bus_b.rd_addr     : bus_a.rd_addr;
  assign m_dir    = sel ? bus_b.shift_direc : bus_a.shift_direc;
  assign m_wx     = sel ? bus_b.win_x       : bus_a.win_x;
  assign m_wy     = sel ? bus_b.win_y       : bus_a.win_y;

  int total = 0, bad = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected reads (with direction), shifts and windows of one frame.
  int unsigned exp_addr[$];
  int exp_rdir[$], exp_sdir[$], exp_wx[$], exp_wy[$];
  int rd_pos = 0, sh_pos = 0, win_pos = 0, done_cnt = 0;

  task automatic build_model(input int w, input int h, input int unsigned base);
    int px[$], py[$];
    int d;
    exp_addr.delete(); exp_rdir.delete(); exp_sdir.delete(); exp_wx.delete(); exp_wy.delete();
    for (int y = 0; y <= h - 3; y++)
      for (int k = 0; k <= w - 3; k++) begin
        px.push_back((y % 2 == 0) ? k : (w - 3 - k));
        py.push_back(y);
      end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        exp_addr.push_back((base + (py[0] + r) * w + px[0] + c) & 32'hFFFFF);
        exp_rdir.push_back(0);
      end
    for (int i = 1; i < px.size(); i++) begin
      d = (px[i] > px[i-1]) ? 1 : (px[i] < px[i-1]) ? 2 : 3;
      exp_sdir.push_back(d);
      for (int j = 0; j < 3; j++) begin
        if (d == 3) exp_addr.push_back((base + (py[i] + 2) * w + px[i] + j) & 32'hFFFFF);
        else exp_addr.push_back((base + (py[i] + j) * w + px[i] + ((d == 1) ? 2 : 0)) & 32'hFFFFF);
        exp_rdir.push_back(d);
      end
    end
    foreach (px[i]) begin
      exp_wx.push_back(px[i] + 1);
      exp_wy.push_back(py[i] + 1);
    end
  endtask

  // Responder: per-request ack latency (fixed or random), calc_done after win_valid.
  int lat_fix = 0, cdly = 2, cur_lat = 0, wait_cnt = 0, calc_cnt = -1;
  bit noise = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (m_req) begin
        if (wait_cnt >= cur_lat) begin
          ack_v = 1'b1; wait_cnt = 0;
          cur_lat = (lat_fix < 0) ? int'($urandom_range(0, 3)) : lat_fix;
        end else begin
          ack_v = 1'b0; wait_cnt++;
        end
      end else begin
        ack_v = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        wait_cnt = 0;
      end
      calc_v = 1'b0;
      if (m_wv) calc_cnt = cdly;
      if (calc_cnt == 0) begin calc_v = 1'b1; calc_cnt = -1; end
      else if (calc_cnt > 0) calc_cnt--;
      if (noise && m_req && ($urandom_range(0, 3) == 0)) calc_v = 1'b1;
    end
  end

  // Compare process: checks every handshake output against the model each cycle.
  bit mon_en = 1'b0, prev_req = 1'b0, prev_ack = 1'b0, prev_done = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!n_rst || !mon_en) begin
      prev_req = 1'b0; prev_done = 1'b0;
    end else begin
      chk("start_read", m_sread, m_req && m_ack);
      if (prev_req && !prev_ack) begin
        chk("rd_req_held", m_req, 1);
        chk("rd_addr_stable", m_addr, prev_addr);
      end
      if (m_req && m_ack) begin
        if (rd_pos < exp_addr.size()) begin
          chk("rd_addr", m_addr, exp_addr[rd_pos]);
          chk("read_direc", m_dir, exp_rdir[rd_pos]);
        end else chk("extra_read", rd_pos, exp_addr.size());
        rd_pos++;
      end
      if (m_sshift) begin
        chk("shift_req_low", m_req, 0);
        if (sh_pos < exp_sdir.size()) chk("shift_direc", m_dir, exp_sdir[sh_pos]);
        else chk("extra_shift", sh_pos, exp_sdir.size());
        sh_pos++;
      end
      if (m_wv) begin
        chk("compute_req_low", m_req, 0);
        if (win_pos < exp_wx.size()) begin
          chk("win_x", m_wx, exp_wx[win_pos]);
          chk("win_y", m_wy, exp_wy[win_pos]);
        end else chk("extra_window", win_pos, exp_wx.size());
        win_pos++;
      end
      if (m_done) begin
        chk("busy_at_done", m_busy, 1);
        chk("reads_total", rd_pos, exp_addr.size());
        chk("windows_total", win_pos, exp_wx.size());
        done_cnt++;
      end
      if (prev_done) chk("busy_clear", m_busy, 0);
      prev_req = m_req; prev_ack = m_ack; prev_addr = m_addr; prev_done = m_done;
    end
  end

  task automatic run_frame(input bit s, input int w, input int h, input int unsigned base,
                           input int lat, input int cd, input bit nz, input int mid);
    int d0;
    bit fin;
    sel = s; lat_fix = lat; cur_lat = (lat < 0) ? 0 : lat; cdly = cd; noise = nz;
    build_model(w, h, base);
    rd_pos = 0; sh_pos = 0; win_pos = 0; d0 = done_cnt; fin = 1'b0;
    @(negedge clk); mon_en = 1'b1; base_v = AW'(base); start_v = 1'b1;
    @(negedge clk); start_v = 1'b0; base_v = AW'($urandom);
    chk("busy_set", m_busy, 1);
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      if (c == mid) begin start_v = 1'b1; base_v = AW'(base ^ 32'h40000); end
      else start_v = 1'b0;
      if (done_cnt != d0) fin = 1'b1;
    end
    start_v = 1'b0;
    if (!fin) chk("frame_timeout", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    chk("frame_done_once", done_cnt - d0, 1);
    chk("idle_busy", m_busy, 0);
  endtask

  initial begin
    int polls;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_rd_req", bus_a.rd_req, 0);
    chk("rst_rd_addr", bus_a.rd_addr, 0);
    chk("rst_win_valid", bus_b.win_valid, 0);
    chk("rst_frame_done", bus_b.frame_done, 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    build_model(4, 4, 32'h100);
    chk("model_reads", exp_addr.size(), 18);
    chk("model_addr9", exp_addr[9], 32'h103);
    chk("model_addr12", exp_addr[12], 32'h10D);
    chk("model_addr15", exp_addr[15], 32'h104);
    chk("model_addr17", exp_addr[17], 32'h10C);
    chk("model_dirs", {exp_sdir[0][1:0], exp_sdir[1][1:0], exp_sdir[2][1:0]}, 6'b01_11_10);
    chk("model_win3", {exp_wx[3][3:0], exp_wy[3][3:0]}, 8'h12);
    build_model(3, 5, 32'h0);
    chk("model_3x5_reads", exp_addr.size(), 15);
    chk("model_3x5_dirs", {exp_sdir[0][1:0], exp_sdir[1][1:0]}, 4'b1111);

    run_frame(1'b0, 4, 4, 32'h100, 0, 2, 1'b0, -1);
    run_frame(1'b0, 4, 4, 32'h100, 3, 2, 1'b0, -1);
`ifdef SCAN_PERF_EN
    chk("perf_windows", bus_a.perf_windows, 4);
    chk("perf_stall", bus_a.perf_stall, 54);
`endif
    run_frame(1'b1, 3, 5, 32'h3000, 0, 2, 1'b0, -1);
    run_frame(1'b0, 4, 4, 32'h100, 1, 2, 1'b0, 20);

    // Asynchronous reset while fetching after the first shift.
    sel = 1'b0; lat_fix = 2; cur_lat = 2; noise = 1'b0; build_model(4, 4, 32'h200);
    rd_pos = 0; sh_pos = 0; win_pos = 0;
    @(negedge clk); mon_en = 1'b1; base_v = 20'h200; start_v = 1'b1;
    @(negedge clk); start_v = 1'b0;
    polls = 0;
    while (sh_pos == 0 && polls < 500) begin @(negedge clk); polls++; end
    while (!m_req && polls < 500) begin @(negedge clk); polls++; end
    chk("reach_fetch", polls < 500, 1);
    mon_en = 1'b0; n_rst = 1'b0; #1;
    chk("arst_busy", m_busy, 0);
    chk("arst_rd_req", m_req, 0);
    chk("arst_start_read", m_sread, 0);
    chk("arst_rd_addr", m_addr, 0);
    chk("arst_direc", m_dir, 0);
    chk("arst_win", {m_wv, m_wx, m_wy, m_sshift, m_done}, 0);
    @(negedge clk); n_rst = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(1'b0, 4, 4, 32'h200, 0, 1, 1'b0, -1);

    for (int i = 0; i < 6; i++) begin
      bit s;
      s = 1'($urandom_range(0, 1));
      run_frame(s, s ? 3 : 4, s ? 5 : 4, $urandom_range(0, 32'hF0000), -1,
                int'($urandom_range(0, 4)), 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_scan_controller.md
Name: sobel_scan_controller

Overview:
- Sequences the 3x3 window buffer across a WIDTH x HEIGHT 8-bit frame in a serpentine scan.
- Issues pixel read requests to frame memory, pulses the buffer's start_read/start_shift with the correct shift_direc, and hands each completed window to the Sobel compute stage.
- Sits between the top-level frame control, the frame memory port and the window buffer.

Parameters:
- WIDTH, 640, frame width in pixels, minimum 3
- HEIGHT, 480, frame height in pixels, minimum 3
- ADDR_W, 20, memory byte-address width

Ports:
- clk  input  1  clock
- n_rst  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse that begins a frame; ignored while busy
- img_base  input  ADDR_W  frame base address, sampled on accepted start
- busy  output  1  high from accepted start through frame_done
- frame_done  output  1  one-cycle pulse after the last window's calc_done
- rd_req  output  1  read request; held until rd_ack
- rd_addr  output  ADDR_W  read address; stable while rd_req is high
- rd_ack  input  1  memory data valid this cycle; data drives the buffer's data_r directly
- start_shift  output  1  one-cycle pulse to the window buffer
- start_read  output  1  equals rd_req AND rd_ack (same cycle)
- shift_direc  output  2  00 load, 01 move right, 10 move left, 11 move down
- win_valid  output  1  one-cycle pulse: buffer holds a complete window
- win_x  output  16  window centre column (wx+1)
- win_y  output  16  window centre row (wy+1)
- calc_done  input  1  Sobel stage finished the current window

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- Window top-left (wx,wy): wx in 0..WIDTH-3, wy in 0..HEIGHT-3.
- Address = base + row*WIDTH + col. Maintain a row_base register stepped by +WIDTH; no multiplier.
- States: IDLE, LOAD, SHIFT, FETCH, COMPUTE, DONE.
- IDLE: on start, latch img_base, set wx=wy=0, shift_direc=00, go to LOAD.
- LOAD: 9 reads with shift_direc=00, order row wy cols wx..wx+2, then row wy+1, then row wy+2. Advance the read index only on rd_ack. After the 9th ack, go to COMPUTE.
- COMPUTE: pulse win_valid on entry, then wait for calc_done.
  - calc_done at the last position (wx=WIDTH-3 and wy=HEIGHT-3 on an even row band, or wx=0 on an odd band): go to DONE.
  - Else choose direction. Even band (wy even): 01 if wx<WIDTH-3, else 11. Odd band: 10 if wx>0, else 11.
  - Then go to SHIFT.
- SHIFT: one cycle with start_shift=1 and shift_direc set. Update wx/wy: +1 col, -1 col, or +1 row. Go to FETCH.
- FETCH: 3 reads with shift_direc held.
  - 01: col wx+2 (new), rows wy, wy+1, wy+2.
  - 10: col wx (new), rows wy, wy+1, wy+2.
  - 11: row wy+2 (new), cols wx, wx+1, wx+2.
  - After the 3rd ack, go to COMPUTE.
- DONE: pulse frame_done for one cycle, clear busy, go to IDLE.
- rd_req may rise the cycle after entering LOAD/FETCH. Back-to-back reads are allowed: rd_addr advances the cycle after an ack. rd_req stays 0 in SHIFT, COMPUTE and IDLE.
- calc_done outside COMPUTE: ignored. rd_ack without rd_req: ignored.
- start during busy: ignored; no latch of img_base.
- Asynchronous reset mid-frame: immediately return to IDLE with all outputs 0. The buffer contents become don't-care.
- WIDTH=3: no horizontal moves; every step is 11. HEIGHT=3: single band; frame_done after the row.
- Total reads per frame = 9 + 3*(windows-1).

Optional Feature:
- SCAN_PERF_EN
- Defined:
  - Adds output perf_stall [31:0], counting cycles with rd_req=1 and rd_ack=0.
  - Adds output perf_windows [31:0], counting win_valid pulses.
  - Both clear on accepted start, saturate at all-ones, and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sobel_pkg: shift_direc enum (DIR_LOAD=00, DIR_RIGHT=01, DIR_LEFT=10, DIR_DOWN=11), scan state enum, WIN_SIZE=3, WIN_PIXELS=9.
- Sub-module scan_addr_gen: holds wx/wy/row_base/read index, produces rd_addr and last-read/last-window flags. The FSM stays in the top.

Test Plan:
- WIDTH=4, HEIGHT=4, base=0x100, rd_ack every cycle, calc_done 2 cycles after win_valid -> read addresses 0x100,101,102,104,105,106,108,109,10A; then 103,107,10B (dir 01); 10D,10E,10F (dir 11); 104,108,10C (dir 10). win (x,y) sequence (1,1),(2,1),(2,2),(1,2). One frame_done, 18 acks total.
- Same frame with rd_ack delayed 3 cycles per request -> rd_addr stable while rd_req is high, identical address sequence, start_read only on ack cycles.
- WIDTH=3, HEIGHT=5 -> directions only 11, three windows, 15 reads, frame_done once.
- start pulsed mid-frame with a different img_base -> ignored; addresses continue from the original base.
- n_rst asserted during FETCH -> all outputs 0 in the same cycle. A new start afterwards runs a full LOAD from wx=wy=0.
- With SCAN_PERF_EN, the 4x4 frame with 3-cycle ack latency -> perf_windows=4, perf_stall=54.
